// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the IR register list in ascending order,
// issuing one held memory request per register, then an optional base writeback.
module ldm_stm_sequencer #(
    parameter int STEP    = 4,
    parameter int TIMEOUT = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [31:0] IR,
    input  logic [31:0] rn_value,
    input  logic        MOC,
    output logic        busy,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [3:0]  reg_idx,
    output logic        rf_we,
    output logic        wb_we,
    output logic [3:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err,
    output logic [2:0]  state_dbg
);

    // Memory handshake: while mem_en is high, mem_rw/mem_addr/reg_idx form one request
    // held unchanged until MOC is sampled high on a rising edge; MOC is ignored otherwise.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_XFER   = 3'd2,
        S_COMMIT = 3'd3,
        S_WB     = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [31:0] STEP_W  = 32'(STEP);
    localparam logic        TO_EN   = (TIMEOUT > 0);
    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state, state_d;
    logic        p_q, u_q, w_q, l_q;
    logic [3:0]  rn_idx_q;
    logic [15:0] list_orig_q;
    logic [15:0] list_q;
    logic [31:0] rn_q;
    logic [31:0] addr_q;
    logic [31:0] final_q;
    logic [4:0]  count_q;
    logic [31:0] wait_q;
    logic        err_q;

    logic        accept;
    logic [4:0]  list_pop;
    logic [3:0]  first_idx;
    logic [15:0] list_next;
    logic [31:0] step_n;
    logic [31:0] start_addr;
    logic [31:0] final_base;
    logic        wb_ok;
    logic        timeout_hit;

    // Condition code and S bit are not used by the sequencer.
    logic ir_unused;
    assign ir_unused = ^{IR[31:28], IR[22]};

    assign accept = (state == S_IDLE) && start && (IR[27:25] == 3'b100);

    always_comb begin
        list_pop = '0;
        for (int i = 0; i < 16; i++) begin
            list_pop = list_pop + {4'b0, IR[i]};
        end
    end

    always_comb begin
        first_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) first_idx = 4'(i);
        end
    end

    assign list_next = list_q & (list_q - 16'd1);
    assign step_n    = 32'(count_q) * STEP_W;

    always_comb begin
        start_addr = rn_q;
        case ({p_q, u_q})
            2'b01:   start_addr = rn_q;
            2'b11:   start_addr = rn_q + STEP_W;
            2'b00:   start_addr = rn_q - step_n + STEP_W;
            default: start_addr = rn_q - step_n;
        endcase
    end

    assign final_base = u_q ? (rn_q + step_n) : (rn_q - step_n);
    // A load that targets its own base keeps the loaded value, so writeback is dropped.
    assign wb_ok       = w_q && !(l_q && list_orig_q[rn_idx_q]);
    assign timeout_hit = TO_EN && (wait_q == TO_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (accept) state_d = S_SETUP;
            S_SETUP: begin
                if (count_q != 5'd0) state_d = S_XFER;
                else if (wb_ok)      state_d = S_WB;
                else                 state_d = S_DONE;
            end
            S_XFER: begin
                if (MOC)              state_d = S_COMMIT;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_COMMIT: begin
                if (list_next != 16'd0) state_d = S_XFER;
                else if (wb_ok)         state_d = S_WB;
                else                    state_d = S_DONE;
            end
            S_WB:     state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_q         <= 1'b0;
            u_q         <= 1'b0;
            w_q         <= 1'b0;
            l_q         <= 1'b0;
            rn_idx_q    <= '0;
            list_orig_q <= '0;
            list_q      <= '0;
            rn_q        <= '0;
            addr_q      <= '0;
            final_q     <= '0;
            count_q     <= '0;
            wait_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        p_q         <= IR[24];
                        u_q         <= IR[23];
                        w_q         <= IR[21];
                        l_q         <= IR[20];
                        rn_idx_q    <= IR[19:16];
                        list_orig_q <= IR[15:0];
                        list_q      <= IR[15:0];
                        rn_q        <= rn_value;
                        count_q     <= list_pop;
                        err_q       <= 1'b0;
                    end
                end
                S_SETUP: begin
                    addr_q  <= start_addr;
                    final_q <= final_base;
                    wait_q  <= '0;
                end
                S_XFER: begin
                    wait_q <= wait_q + 32'd1;
                    if (!MOC && timeout_hit) err_q <= 1'b1;
                end
                S_COMMIT: begin
                    list_q <= list_next;
                    addr_q <= addr_q + STEP_W;
                    wait_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign mem_en    = (state == S_XFER);
    assign mem_rw    = mem_en & l_q;
    assign mem_addr  = addr_q;
    assign reg_idx   = first_idx;
    assign rf_we     = (state == S_COMMIT) & l_q;
    assign wb_we     = (state == S_WB);
    assign wb_reg    = rn_idx_q;
    assign wb_data   = final_q;
    assign done      = (state == S_DONE);
    assign err       = done & err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: expected transfers and writebacks are queued when an
// instruction is issued and popped as the sequencer produces them.
`timescale 1ns/1ps
module tb_ldm_stm_sequencer;

    localparam int MOC_DLY   = 0;
    localparam int MOC_TIE   = 1;
    localparam int MOC_STUCK = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [31:0] IR = '0;
    logic [31:0] rn_value = '0;
    logic        MOC = 1'b0;

    logic        busy, mem_en, mem_rw, rf_we, wb_we, done, err;
    logic [31:0] mem_addr, wb_data;
    logic [3:0]  reg_idx, wb_reg;
    logic [2:0]  state_dbg;

    logic        t_busy, t_mem_en, t_mem_rw, t_rf_we, t_wb_we, t_done, t_err;
    logic [31:0] t_mem_addr, t_wb_data;
    logic [3:0]  t_reg_idx, t_wb_reg;
    logic [2:0]  t_state_dbg;

    ldm_stm_sequencer #(.STEP(4), .TIMEOUT(0)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .IR(IR), .rn_value(rn_value), .MOC(MOC),
        .busy(busy), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .reg_idx(reg_idx), .rf_we(rf_we), .wb_we(wb_we), .wb_reg(wb_reg),
        .wb_data(wb_data), .done(done), .err(err), .state_dbg(state_dbg)
    );

    ldm_stm_sequencer #(.STEP(4), .TIMEOUT(8)) dut_to (
        .CLK(CLK), .RST_N(RST_N), .start(start), .IR(IR), .rn_value(rn_value), .MOC(MOC),
        .busy(t_busy), .mem_en(t_mem_en), .mem_rw(t_mem_rw), .mem_addr(t_mem_addr),
        .reg_idx(t_reg_idx), .rf_we(t_rf_we), .wb_we(t_wb_we), .wb_reg(t_wb_reg),
        .wb_data(t_wb_data), .done(t_done), .err(t_err), .state_dbg(t_state_dbg)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_q[$];
    logic [35:0] wb_q[$];

    int          moc_mode = MOC_DLY;
    int          moc_delay = 0;
    int          hold_cnt = 0;
    logic [36:0] hold_word = '0;
    logic [3:0]  last_reg = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wb_data = '0;
    int          last_hold_len = 0;
    int          mem_cycles = 0;
    int          rf_cnt = 0;
    int          done_cnt = 0;
    int          wb_cnt = 0;
    logic        last_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        start = 1'b0;
        MOC   = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({busy, mem_en, mem_rw, reg_idx, rf_we, wb_we, wb_reg,
                                 done, err, state_dbg}), 64'd0);
        check({tag, "_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_wbdata"}, 64'(wb_data), 64'd0);
        check({tag, "_t_ctl"}, 64'({t_busy, t_mem_en, t_mem_rw, t_reg_idx, t_rf_we, t_wb_we,
                                   t_wb_reg, t_done, t_err, t_state_dbg}), 64'd0);
        check({tag, "_t_data"}, {t_mem_addr, t_wb_data}, 64'd0);
    endtask

    // Called once per falling edge: observes the DUT and sets MOC for the next rising edge.
    task automatic monitor_cycle();
        logic [36:0] cur;
        logic [36:0] e;
        logic [35:0] w;
        cur = {mem_rw, reg_idx, mem_addr};
        if (mem_en) begin
            mem_cycles++;
            if (hold_cnt == 0) hold_word = cur;
            else check("hold_stable", 64'(cur), 64'(hold_word));
        end
        case (moc_mode)
            MOC_TIE:   MOC = 1'b1;
            MOC_STUCK: MOC = 1'b0;
            default:   MOC = mem_en && (hold_cnt == moc_delay);
        endcase
        if (mem_en && MOC) begin
            check("xfer_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("xfer", 64'(cur), 64'(e));
            end
            last_reg      = reg_idx;
            last_addr     = mem_addr;
            last_hold_len = hold_cnt + 1;
            hold_cnt      = 0;
        end else if (mem_en) begin
            hold_cnt++;
        end else begin
            hold_cnt = 0;
        end
        if (rf_we) begin
            rf_cnt++;
            check("rf_idx", 64'(reg_idx), 64'(last_reg));
        end
        if (wb_we) begin
            wb_cnt++;
            last_wb_data = wb_data;
            check("wb_pending", 64'(wb_q.size() != 0), 64'd1);
            if (wb_q.size() != 0) begin
                w = wb_q.pop_front();
                check("wb", 64'({wb_reg, wb_data}), 64'(w));
            end
        end
        if (done) begin
            done_cnt++;
            last_err = err;
        end
    endtask

    task automatic run_op(input logic [31:0] ir, input logic [31:0] rn, input int delay,
                          input int poke_at, output int lat);
        logic        p, u, w, l;
        logic [3:0]  rnx;
        logic [15:0] list;
        logic [31:0] a, fin, stepn;
        logic        wb;
        int          n, d, exp_lat, m0, r0, d0;
        bit          finished;
        exp_q.delete();
        wb_q.delete();
        p = ir[24]; u = ir[23]; w = ir[21]; l = ir[20];
        rnx = ir[19:16];
        list = ir[15:0];
        n = $countones(list);
        stepn = 32'(4 * n);
        case ({p, u})
            2'b01:   a = rn;
            2'b11:   a = rn + 32'd4;
            2'b00:   a = rn - stepn + 32'd4;
            default: a = rn - stepn;
        endcase
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                exp_q.push_back({l, 4'(i), a});
                a = a + 32'd4;
            end
        end
        fin = u ? rn + stepn : rn - stepn;
        wb = w && !(l && list[rnx]);
        if (wb) wb_q.push_back({rnx, fin});
        d = (moc_mode == MOC_TIE) ? 0 : delay;
        moc_delay = delay;
        exp_lat = 2 + n * (d + 2) + (wb ? 1 : 0);
        m0 = mem_cycles; r0 = rf_cnt; d0 = done_cnt;
        last_err = 1'b0;

        @(negedge CLK);
        IR = ir; rn_value = rn; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0; IR = ~ir; rn_value = ~rn;
        lat = 0;
        finished = 1'b0;
        while (!finished) begin
            @(negedge CLK);
            start = 1'b0;
            monitor_cycle();
            lat++;
            if (done) finished = 1'b1;
            else if (lat >= 200) begin
                check("done_timeout", 64'(lat), 64'(exp_lat));
                finished = 1'b1;
            end else if (lat == poke_at) begin
                start = 1'b1;
                IR = 32'hE880_0200;
            end
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("xfer_left", 64'(exp_q.size()), 64'd0);
        check("wb_left", 64'(wb_q.size()), 64'd0);
        check("rf_count", 64'(rf_cnt - r0), 64'(l ? n : 0));
        check("mem_cycles", 64'(mem_cycles - m0), 64'(n * (d + 1)));
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("err", 64'(last_err), 64'd0);
        @(negedge CLK);
        monitor_cycle();
        check("idle_after", 64'({busy, done, mem_en}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w0, tcyc, txfer;
        logic terr, twb;
        bit tfin;

        #3;
        check_all_zero("reset");
        do_reset();

        // LDMIA R1!,{R0,R3,R5} with MOC tied high
        moc_mode = MOC_TIE;
        run_op(32'hE8B1_0029, 32'h0000_0100, 0, 0, lat);
        check("t1_latency", 64'(lat), 64'd9);
        check("t1_wb_data", 64'(last_wb_data), 64'h10C);
        check("t1_last_addr", 64'(last_addr), 64'h108);

        // STMDB R4!,{R1,R2}
        moc_mode = MOC_DLY;
        run_op(32'hE924_0006, 32'h0000_0200, 1, 0, lat);
        check("t2_wb_data", 64'(last_wb_data), 64'h1F8);
        check("t2_last_addr", 64'(last_addr), 64'h1FC);

        // LDMDA R2,{R7} with MOC three cycles late
        w0 = wb_cnt;
        run_op(32'hE812_0080, 32'h0000_0040, 3, 0, lat);
        check("t3_hold_len", 64'(last_hold_len), 64'd4);
        check("t3_addr", 64'(last_addr), 64'h40);
        check("t3_reg", 64'(last_reg), 64'd7);
        check("t3_no_wb", 64'(wb_cnt - w0), 64'd0);

        // Empty list with writeback, then IB wrapping through zero
        run_op(32'hE8B5_0000, 32'h0000_0080, 0, 0, lat);
        check("t4_wb_data", 64'(last_wb_data), 64'h80);
        check("t4_latency", 64'(lat), 64'd3);
        run_op(32'hE996_0001, 32'hFFFF_FFFC, 0, 0, lat);
        check("t4_wrap_addr", 64'(last_addr), 64'h0);

        // LDMIA R3!,{R3,R4} with a second start pulsed mid-transfer
        w0 = wb_cnt;
        run_op(32'hE8B3_0018, 32'h0000_1000, 1, 3, lat);
        check("t5_no_wb", 64'(wb_cnt - w0), 64'd0);
        check("t5_last_reg", 64'(last_reg), 64'd4);

        // Non-block-transfer opcode is ignored
        @(negedge CLK);
        IR = 32'hEA00_0010; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("bad_op_busy0", 64'(busy), 64'd0);
        @(negedge CLK);
        check("bad_op_busy1", 64'({busy, mem_en, state_dbg}), 64'd0);

        // Random mix of modes, lists and memory delays
        for (int k = 0; k < 8; k++) begin
            logic [15:0] rl;
            logic [31:0] rir;
            rl = 16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535));
            rir = {4'hE, 3'b100, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), rl};
            run_op(rir, $urandom(), $urandom_range(0, 3), 0, lat);
        end

        // Timeout on the TIMEOUT=8 instance with MOC stuck low
        do_reset();
        moc_mode = MOC_STUCK;
        @(negedge CLK);
        IR = 32'hE891_0004; rn_value = 32'h0000_0300; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        tcyc = 0; txfer = 0; terr = 1'b0; twb = 1'b0; tfin = 1'b0;
        while (!tfin) begin
            tcyc++;
            if (t_mem_en) txfer++;
            if (t_wb_we) twb = 1'b1;
            if (t_done) begin
                terr = t_err;
                tfin = 1'b1;
            end else if (tcyc >= 40) begin
                check("t6_done_timeout", 64'(tcyc), 64'd10);
                tfin = 1'b1;
            end else begin
                @(negedge CLK);
                monitor_cycle();
            end
        end
        check("t6_latency", 64'(tcyc), 64'd10);
        check("t6_xfer_cycles", 64'(txfer), 64'd8);
        check("t6_err", 64'(terr), 64'd1);
        check("t6_no_wb", 64'(twb), 64'd0);
        check("t6_wait_forever", 64'({busy, mem_en, mem_rw, reg_idx}), 64'({3'b111, 4'd2}));
        check("t6_wait_addr", 64'(mem_addr), 64'h300);

        // Asynchronous reset while the first instance is waiting in XFER
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge CLK);
        RST_N = 1'b1;
        moc_mode = MOC_DLY;
        @(negedge CLK);
        check("post_reset_idle", 64'({busy, mem_en, state_dbg}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
